uart_rx: RTL

- Asynchronous serial receiver, 8N1 frame: 1 start bit, 8 data bits LSB first, 1 stop bit.
- Receive-side counterpart of the team's serial transmitter. It shares the same baud-rate divisor constants.
- Sits between the board RX pin and user logic. Delivers each received byte with a one-cycle strobe and flags framing errors.

---
 rtl/uart_rx_pkg.sv | 23 ++
 rtl/baudgen_rx.sv | 40 ++++
 rtl/uart_rx.sv | 136 +++++++++++++
 3 files changed

// File: rtl/uart_rx_pkg.sv
// Shared baud divisor constants (clk cycles per bit at 12 MHz) and divider helpers.
// Combinational constants only; no latency, no backpressure.
package uart_rx_pkg;

    localparam int B115200 = 104;
    localparam int B57600  = 208;
    localparam int B38400  = 313;
    localparam int B19200  = 625;
    localparam int B9600   = 1250;
    localparam int B4800   = 2500;
    localparam int B2400   = 5000;
    localparam int B1200   = 10000;
    localparam int B600    = 20000;
    localparam int B300    = 40000;

    // The divider reloads one cycle after start detection and the FSM acts one cycle
    // after terminal count, so the preload absorbs those two cycles to land the
    // START sample exactly baud/2 cycles after the edge was detected.
    function automatic logic [15:0] first_tick_load(input int baud);
        return 16'(baud + 1 - baud / 2);
    endfunction

endpackage

// File: rtl/baudgen_rx.sv
// Receive baud divider: first clk_out pulse BAUDRATE/2 cycles after clk_ena rises, then every BAUDRATE.
// Output is combinational from the counter; no backpressure, counter held at 0 while disabled.
module baudgen_rx
    import uart_rx_pkg::*;
#(
    parameter int BAUDRATE = B115200
)
(
    input  logic clk,
    input  logic rstn,
    input  logic clk_ena,
    output logic clk_out
);

    localparam logic [15:0] TERM = 16'(BAUDRATE - 1);
    localparam logic [15:0] LOAD = first_tick_load(BAUDRATE);

    logic [15:0] cnt;
    logic        ena_d;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt   <= '0;
            ena_d <= 1'b0;
        end else begin
            ena_d <= clk_ena;
            if (!clk_ena)
                cnt <= '0;
            else if (!ena_d)
                cnt <= LOAD;
            else if (cnt == TERM)
                cnt <= '0;
            else
                cnt <= cnt + 16'd1;
        end
    end

    assign clk_out = clk_ena && ena_d && (cnt == TERM);

endmodule

// File: rtl/uart_rx.sv
// 8N1 serial receiver: single mid-bit sample, byte strobe on rcv, stop-bit error strobe on frame_err.
// rcv/frame_err one cycle after the stop-bit mid-sample (~9.5 bits + 3 clk); no backpressure, strobes are not held.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int BAUDRATE = B115200
)
(
    input  logic       clk,
    input  logic       rstn,
    input  logic       rx,
    output logic [7:0] data,
    output logic       rcv,
    output logic       frame_err,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        rx_q;
    logic        rx_s;
    logic        tick;
    logic [3:0]  bitc;
    logic [7:0]  shift;
    logic        shift_en;
    logic        bitc_clr;
    logic        load_data;
    logic        set_ferr;

    // Preset high so reset never fabricates a start edge from stale flop contents.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            rx_q <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_q <= rx;
            rx_s <= rx_q;
        end
    end

    baudgen_rx #(
        .BAUDRATE (BAUDRATE)
    ) u_baudgen (
        .clk     (clk),
        .rstn    (rstn),
        .clk_ena (busy),
        .clk_out (tick)
    );

    always_ff @(posedge clk) begin
        if (!rstn)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        shift_en  = 1'b0;
        bitc_clr  = 1'b0;
        load_data = 1'b0;
        set_ferr  = 1'b0;
        unique case (state)
            IDLE: begin
                if (!rx_s)
                    state_nxt = START;
            end
            START: begin
                if (tick) begin
                    if (rx_s) begin
                        state_nxt = IDLE;
                    end else begin
                        bitc_clr  = 1'b1;
                        state_nxt = DATA;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    shift_en = 1'b1;
                    if (bitc == 4'd7)
                        state_nxt = STOP;
                end
            end
            STOP: begin
                // Leaving STOP at mid-bit lets a start edge right after the stop bit be caught.
                if (tick) begin
                    if (rx_s) begin
                        load_data = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        set_ferr  = 1'b1;
                        state_nxt = BREAK;
                    end
                end
            end
            BREAK: begin
                if (rx_s)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            data      <= 8'h00;
            rcv       <= 1'b0;
            frame_err <= 1'b0;
            bitc      <= 4'd0;
            shift     <= 8'h00;
        end else begin
            rcv       <= load_data;
            frame_err <= set_ferr;
            if (bitc_clr)
                bitc <= 4'd0;
            else if (shift_en)
                bitc <= bitc + 4'd1;
            if (shift_en)
                shift <= {rx_s, shift[7:1]};
            if (load_data)
                data <= shift;
        end
    end

    assign busy = (state != IDLE);

endmodule
